// File: rtl/capture_mem_ctrl.sv
// capture_mem_ctrl: pre/post-trigger ring-buffer write sequencer and single-bank host readback
// for NUM_BANKS external SRAM macros. Define CAPTURE_MEM_RD_PIPE_EN to register the mem_q select (read latency 4).
module capture_mem_ctrl #(
  parameter int NUM_BANKS = 96,
  parameter int DATA_W    = 9,
  parameter int ADDR_W    = 15,
  parameter int BSEL_W    = 7
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cap_start,
  input  logic                          cap_abort,
  input  logic                          trig,
  input  logic [ADDR_W-1:0]             post_cnt,
  input  logic                          din_vld,
  input  logic [NUM_BANKS*DATA_W-1:0]   din,
  output logic                          busy,
  output logic                          done,
  output logic [ADDR_W-1:0]             trig_addr,
  output logic                          wrapped,
  input  logic                          rd_req,
  input  logic [ADDR_W-1:0]             rd_addr,
  input  logic [BSEL_W-1:0]             rd_bank,
  output logic                          rd_vld,
  output logic [DATA_W-1:0]             rd_data,
  output logic [NUM_BANKS-1:0]          mem_ceb,
  output logic [NUM_BANKS-1:0]          mem_web,
  output logic [NUM_BANKS*ADDR_W-1:0]   mem_addr,
  output logic [NUM_BANKS*DATA_W-1:0]   mem_d,
  input  logic [NUM_BANKS*DATA_W-1:0]   mem_q
);

  typedef enum logic [1:0] {IDLE, ARMED, POST, DONE} state_t;

  state_t              state;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   post_rem;
  logic                rd_accept;
  logic                wr_en;
  logic                rd_s1_vld;
  logic                rd_s2_vld;
  logic [BSEL_W-1:0]   rd_s1_bank;
  logic [BSEL_W-1:0]   rd_s2_bank;
  logic [DATA_W-1:0]   rd_sel;

  assign rd_accept = rd_req && (state == IDLE || state == DONE);
  assign wr_en     = din_vld && !cap_abort && (state == ARMED || state == POST);

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      post_rem   <= '0;
      trig_addr  <= '0;
      wrapped    <= 1'b0;
      busy       <= 1'b0;
      done       <= 1'b0;
      mem_ceb    <= '1;
      mem_web    <= '1;
      mem_addr   <= '0;
      mem_d      <= '0;
      rd_s1_vld  <= 1'b0;
      rd_s1_bank <= '0;
    end else begin
      // Macros are disabled every cycle unless a write or an accepted read claims them.
      mem_ceb    <= '1;
      mem_web    <= '1;
      rd_s1_vld  <= rd_accept;
      rd_s1_bank <= rd_bank;

      if (wr_en) begin
        mem_ceb  <= '0;
        mem_web  <= '0;
        mem_addr <= {NUM_BANKS{wr_ptr}};
        mem_d    <= din;
        wr_ptr   <= wr_ptr + 1'b1;
        if (wr_ptr == '1) wrapped <= 1'b1;
      end

      if (rd_accept) begin
        for (int i = 0; i < NUM_BANKS; i++) begin
          if (rd_bank == BSEL_W'(i)) begin
            mem_ceb[i]                   <= 1'b0;
            mem_addr[ADDR_W*i +: ADDR_W] <= rd_addr;
          end
        end
      end

      case (state)
        IDLE, DONE: begin
          if (cap_start && !cap_abort) begin
            state    <= ARMED;
            busy     <= 1'b1;
            done     <= 1'b0;
            wr_ptr   <= '0;
            wrapped  <= 1'b0;
            post_rem <= post_cnt;
          end
        end
        ARMED: begin
          if (cap_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (din_vld && trig) begin
            trig_addr <= wr_ptr;
            if (post_rem == '0) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state <= POST;
            end
          end
        end
        POST: begin
          if (cap_abort) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else if (din_vld) begin
            post_rem <= post_rem - 1'b1;
            if (post_rem == ADDR_W'(1)) begin
              state <= DONE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          done  <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: give every always_comb output a default first; this prevents a latch and makes
    // an out-of-range bank select read as zero.
    rd_sel = '0;
    for (int i = 0; i < NUM_BANKS; i++) begin
      if (rd_s2_bank == BSEL_W'(i)) rd_sel = mem_q[DATA_W*i +: DATA_W];
    end
  end

`ifdef CAPTURE_MEM_RD_PIPE_EN
  logic              rd_s3_vld;
  logic [DATA_W-1:0] rd_s3_data;
`endif

  // Read return path: stage 2 lines up with the macro output, then the output register.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_s2_vld  <= 1'b0;
      rd_s2_bank <= '0;
      rd_vld     <= 1'b0;
      rd_data    <= '0;
`ifdef CAPTURE_MEM_RD_PIPE_EN
      rd_s3_vld  <= 1'b0;
      rd_s3_data <= '0;
`endif
    end else begin
      rd_s2_vld  <= rd_s1_vld;
      rd_s2_bank <= rd_s1_bank;
`ifdef CAPTURE_MEM_RD_PIPE_EN
      rd_s3_vld  <= rd_s2_vld;
      if (rd_s2_vld) rd_s3_data <= rd_sel;
      rd_vld     <= rd_s3_vld;
      if (rd_s3_vld) rd_data <= rd_s3_data;
`else
      rd_vld     <= rd_s2_vld;
      if (rd_s2_vld) rd_data <= rd_sel;
`endif
    end
  end

endmodule

// File: tb/tb_capture_mem_ctrl.sv
// Directed self-checking bench for capture_mem_ctrl (4 banks, 16-deep ring) with a behavioural
// 1-cycle-latency SRAM model attached to the macro pins.
module tb_capture_mem_ctrl;

  localparam int NB = 4;
  localparam int DW = 9;
  localparam int AW = 4;
  localparam int BW = 3;
`ifdef CAPTURE_MEM_RD_PIPE_EN
  localparam int RD_LAT = 4;
`else
  localparam int RD_LAT = 3;
`endif

  logic              clk;
  logic              rst;
  logic              cap_start;
  logic              cap_abort;
  logic              trig;
  logic [AW-1:0]     post_cnt;
  logic              din_vld;
  logic [NB*DW-1:0]  din;
  logic              busy;
  logic              done;
  logic [AW-1:0]     trig_addr;
  logic              wrapped;
  logic              rd_req;
  logic [AW-1:0]     rd_addr;
  logic [BW-1:0]     rd_bank;
  logic              rd_vld;
  logic [DW-1:0]     rd_data;
  logic [NB-1:0]     mem_ceb;
  logic [NB-1:0]     mem_web;
  logic [NB*AW-1:0]  mem_addr;
  logic [NB*DW-1:0]  mem_d;
  logic [NB*DW-1:0]  mem_q = '0;

  int tests_run = 0;
  int failed    = 0;

  capture_mem_ctrl #(
    .NUM_BANKS(NB), .DATA_W(DW), .ADDR_W(AW), .BSEL_W(BW)
  ) dut (
    .clk(clk), .rst(rst), .cap_start(cap_start), .cap_abort(cap_abort), .trig(trig),
    .post_cnt(post_cnt), .din_vld(din_vld), .din(din), .busy(busy), .done(done),
    .trig_addr(trig_addr), .wrapped(wrapped), .rd_req(rd_req), .rd_addr(rd_addr),
    .rd_bank(rd_bank), .rd_vld(rd_vld), .rd_data(rd_data), .mem_ceb(mem_ceb),
    .mem_web(mem_web), .mem_addr(mem_addr), .mem_d(mem_d), .mem_q(mem_q)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: writes when ceb=0/web=0, otherwise reads with one cycle of latency.
  logic [DW-1:0] mem [NB][1<<AW];
  int            wr_cnt = 0;
  logic [AW-1:0] last_wr_addr = '0;

  always @(posedge clk) begin
    for (int b = 0; b < NB; b++) begin
      if (!mem_ceb[b]) begin
        if (!mem_web[b]) mem[b][mem_addr[AW*b +: AW]] <= mem_d[DW*b +: DW];
        else             mem_q[DW*b +: DW] <= mem[b][mem_addr[AW*b +: AW]];
      end
    end
    if (mem_web != '1) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_addr <= mem_addr[AW-1:0];
    end
  end

  function automatic logic [DW-1:0] samp(input int k, input int i);
    return DW'((k * 37 + i * 101 + 3) % 512);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic set_din(input int k);
    for (int i = 0; i < NB; i++) din[DW*i +: DW] = samp(k, i);
  endtask

  task automatic arm(input logic [AW-1:0] pc);
    post_cnt  = pc;
    cap_start = 1'b1;
    step();
    cap_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL reset_done: got %b want 0", done); end
    tests_run++; if (rd_vld !== 1'b0) begin failed++; $display("FAIL reset_rd_vld: got %b want 0", rd_vld); end
    tests_run++; if (mem_ceb !== 4'hf) begin failed++; $display("FAIL reset_ceb: got %h want f", mem_ceb); end
    tests_run++; if (mem_web !== 4'hf) begin failed++; $display("FAIL reset_web: got %h want f", mem_web); end
    tests_run++; if (trig_addr !== 4'd0) begin failed++; $display("FAIL reset_trig_addr: got %0d want 0", trig_addr); end
    tests_run++; if (wrapped !== 1'b0) begin failed++; $display("FAIL reset_wrapped: got %b want 0", wrapped); end
    rst = 1'b0;
    step();
  endtask

  task automatic test_capture();
    int base;
    base = wr_cnt;
    arm(4'd3);
    tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL cap_armed_busy: got %b want 1", busy); end
    for (int k = 0; k < 9; k++) begin
      din_vld = 1'b1;
      trig    = (k == 5);
      set_din(k);
      step();
      if (k == 5) begin
        tests_run++; if (trig_addr !== 4'd5) begin failed++; $display("FAIL cap_trig_addr_early: got %0d want 5", trig_addr); end
        tests_run++; if (busy !== 1'b1) begin failed++; $display("FAIL cap_post_busy: got %b want 1", busy); end
      end
    end
    din_vld = 1'b0;
    trig    = 1'b0;
    tests_run++; if (done !== 1'b1) begin failed++; $display("FAIL cap_done: got %b want 1", done); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL cap_busy_done: got %b want 0", busy); end
    tests_run++; if (trig_addr !== 4'd5) begin failed++; $display("FAIL cap_trig_addr: got %0d want 5", trig_addr); end
    tests_run++; if (wrapped !== 1'b0) begin failed++; $display("FAIL cap_wrapped: got %b want 0", wrapped); end
    step();
    tests_run++; if (wr_cnt - base !== 9) begin failed++; $display("FAIL cap_wr_count: got %0d want 9", wr_cnt - base); end
    tests_run++; if (last_wr_addr !== 4'd8) begin failed++; $display("FAIL cap_last_addr: got %0d want 8", last_wr_addr); end
    for (int a = 0; a < 9; a++) begin
      for (int b = 0; b < NB; b++) begin
        tests_run++;
        if (mem[b][a] !== samp(a, b)) begin
          failed++; $display("FAIL cap_mem[%0d][%0d]: got %h want %h", b, a, mem[b][a], samp(a, b));
        end
      end
    end
  endtask

  task automatic test_readback();
    logic [AW-1:0] exp_addr;
    logic [DW-1:0] exp_data;
    bit            exp_vld;
    rd_bank = 3'd2;
    rd_addr = 4'd5;
    rd_req  = 1'b1;
    for (int j = 1; j <= 8; j++) begin
      step();
      if (j < 3) rd_addr = AW'(5 + j);
      else       rd_req  = 1'b0;
      if (j <= 3) begin
        exp_addr = AW'(4 + j);
        tests_run++; if (mem_ceb !== 4'b1011) begin failed++; $display("FAIL rd_ceb c%0d: got %b want 1011", j, mem_ceb); end
        tests_run++; if (mem_web !== 4'hf) begin failed++; $display("FAIL rd_web c%0d: got %b want 1111", j, mem_web); end
        tests_run++; if (mem_addr[AW*2 +: AW] !== exp_addr) begin failed++; $display("FAIL rd_addr c%0d: got %0d want %0d", j, mem_addr[AW*2 +: AW], exp_addr); end
      end else begin
        tests_run++; if (mem_ceb !== 4'hf) begin failed++; $display("FAIL rd_ceb_idle c%0d: got %b want 1111", j, mem_ceb); end
      end
      exp_vld = (j >= RD_LAT) && (j < RD_LAT + 3);
      tests_run++; if (rd_vld !== exp_vld) begin failed++; $display("FAIL rd_vld c%0d: got %b want %b", j, rd_vld, exp_vld); end
      if (exp_vld) begin
        exp_data = samp(5 + j - RD_LAT, 2);
        tests_run++; if (rd_data !== exp_data) begin failed++; $display("FAIL rd_data c%0d: got %h want %h", j, rd_data, exp_data); end
      end
    end
    tests_run++; if (rd_data !== samp(7, 2)) begin failed++; $display("FAIL rd_data_hold: got %h want %h", rd_data, samp(7, 2)); end
  endtask

  task automatic test_bad_bank();
    rd_bank = 3'd7;
    rd_addr = 4'd0;
    rd_req  = 1'b1;
    step();
    rd_req = 1'b0;
    tests_run++; if (mem_ceb !== 4'hf) begin failed++; $display("FAIL badbank_ceb: got %b want 1111", mem_ceb); end
    for (int j = 2; j <= RD_LAT; j++) step();
    tests_run++; if (rd_vld !== 1'b1) begin failed++; $display("FAIL badbank_vld: got %b want 1", rd_vld); end
    tests_run++; if (rd_data !== 9'd0) begin failed++; $display("FAIL badbank_data: got %h want 0", rd_data); end
    step();
  endtask

  task automatic test_wrap();
    int base;
    base = wr_cnt;
    arm(4'd0);
    tests_run++; if (wrapped !== 1'b0) begin failed++; $display("FAIL wrap_cleared_on_arm: got %b want 0", wrapped); end
    for (int k = 0; k <= 20; k++) begin
      din_vld = 1'b1;
      trig    = (k == 20);
      set_din(k + 100);
      step();
      if (k == 14) begin
        tests_run++; if (wrapped !== 1'b0) begin failed++; $display("FAIL wrap_early: got %b want 0", wrapped); end
      end
      if (k == 15) begin
        tests_run++; if (wrapped !== 1'b1) begin failed++; $display("FAIL wrap_at_15: got %b want 1", wrapped); end
      end
    end
    tests_run++; if (done !== 1'b1) begin failed++; $display("FAIL wrap_done: got %b want 1", done); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL wrap_busy: got %b want 0", busy); end
    tests_run++; if (trig_addr !== 4'd4) begin failed++; $display("FAIL wrap_trig_addr: got %0d want 4", trig_addr); end
    tests_run++; if (wrapped !== 1'b1) begin failed++; $display("FAIL wrap_flag: got %b want 1", wrapped); end
    for (int j = 0; j < 3; j++) begin
      set_din(300 + j);
      step();
      tests_run++; if (mem_ceb !== 4'hf) begin failed++; $display("FAIL wrap_no_write c%0d: got %b want 1111", j, mem_ceb); end
    end
    din_vld = 1'b0;
    trig    = 1'b0;
    step();
    tests_run++; if (wr_cnt - base !== 21) begin failed++; $display("FAIL wrap_wr_count: got %0d want 21", wr_cnt - base); end
    tests_run++; if (last_wr_addr !== 4'd4) begin failed++; $display("FAIL wrap_last_addr: got %0d want 4", last_wr_addr); end
    for (int b = 0; b < NB; b++) begin
      tests_run++; if (mem[b][4] !== samp(120, b)) begin failed++; $display("FAIL wrap_mem[%0d][4]: got %h want %h", b, mem[b][4], samp(120, b)); end
      tests_run++; if (mem[b][3] !== samp(119, b)) begin failed++; $display("FAIL wrap_mem[%0d][3]: got %h want %h", b, mem[b][3], samp(119, b)); end
      tests_run++; if (mem[b][5] !== samp(105, b)) begin failed++; $display("FAIL wrap_mem[%0d][5]: got %h want %h", b, mem[b][5], samp(105, b)); end
    end
  endtask

  task automatic test_read_while_busy();
    arm(4'd2);
    rd_bank = 3'd1;
    rd_addr = 4'd3;
    rd_req  = 1'b1;
    step();
    rd_req = 1'b0;
    tests_run++; if (mem_ceb !== 4'hf) begin failed++; $display("FAIL busyrd_ceb: got %b want 1111", mem_ceb); end
    for (int j = 2; j <= 6; j++) begin
      step();
      tests_run++; if (rd_vld !== 1'b0) begin failed++; $display("FAIL busyrd_vld c%0d: got %b want 0", j, rd_vld); end
    end
    cap_abort = 1'b1;
    step();
    cap_abort = 1'b0;
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL busyrd_abort_busy: got %b want 0", busy); end
  endtask

  task automatic test_abort();
    int base;
    base = wr_cnt;
    arm(4'd3);
    din_vld = 1'b1;
    trig    = 1'b1;
    set_din(200);
    step();
    trig = 1'b0;
    set_din(201);
    step();
    cap_abort = 1'b1;
    set_din(202);
    step();
    cap_abort = 1'b0;
    din_vld   = 1'b0;
    tests_run++; if (mem_web !== 4'hf) begin failed++; $display("FAIL abort_web: got %b want 1111", mem_web); end
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL abort_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL abort_done: got %b want 0", done); end
    tests_run++; if (trig_addr !== 4'd0) begin failed++; $display("FAIL abort_trig_addr: got %0d want 0", trig_addr); end
    step();
    tests_run++; if (wr_cnt - base !== 2) begin failed++; $display("FAIL abort_wr_count: got %0d want 2", wr_cnt - base); end
    tests_run++; if (last_wr_addr !== 4'd1) begin failed++; $display("FAIL abort_last_addr: got %0d want 1", last_wr_addr); end
    din_vld = 1'b1;
    step();
    din_vld = 1'b0;
    tests_run++; if (mem_web !== 4'hf) begin failed++; $display("FAIL abort_idle_web: got %b want 1111", mem_web); end
  endtask

  task automatic test_reset_mid_post();
    int base;
    arm(4'd5);
    for (int k = 0; k < 6; k++) begin
      din_vld = 1'b1;
      trig    = (k == 3);
      set_din(k + 400);
      step();
    end
    trig = 1'b0;
    tests_run++; if (busy !== 1'b1 || trig_addr !== 4'd3) begin failed++; $display("FAIL rstpost_pre: busy %b trig_addr %0d want 1 3", busy, trig_addr); end
    rst = 1'b1;
    set_din(406);
    step();
    rst     = 1'b0;
    din_vld = 1'b0;
    tests_run++; if (busy !== 1'b0) begin failed++; $display("FAIL rstpost_busy: got %b want 0", busy); end
    tests_run++; if (done !== 1'b0) begin failed++; $display("FAIL rstpost_done: got %b want 0", done); end
    tests_run++; if (trig_addr !== 4'd0) begin failed++; $display("FAIL rstpost_trig_addr: got %0d want 0", trig_addr); end
    tests_run++; if (wrapped !== 1'b0) begin failed++; $display("FAIL rstpost_wrapped: got %b want 0", wrapped); end
    tests_run++; if (rd_vld !== 1'b0 || rd_data !== 9'd0) begin failed++; $display("FAIL rstpost_rd: vld %b data %h want 0 0", rd_vld, rd_data); end
    tests_run++; if (mem_ceb !== 4'hf || mem_web !== 4'hf) begin failed++; $display("FAIL rstpost_ceb_web: got %b %b want 1111 1111", mem_ceb, mem_web); end
    tests_run++; if (mem_addr !== '0) begin failed++; $display("FAIL rstpost_mem_addr: got %h want 0", mem_addr); end
    tests_run++; if (mem_d !== '0) begin failed++; $display("FAIL rstpost_mem_d: got %h want 0", mem_d); end
    base = wr_cnt;
    arm(4'd2);
    din_vld = 1'b1;
    set_din(500);
    step();
    din_vld = 1'b0;
    step();
    tests_run++; if (wr_cnt - base !== 1) begin failed++; $display("FAIL rstpost_rearm_count: got %0d want 1", wr_cnt - base); end
    tests_run++; if (last_wr_addr !== 4'd0) begin failed++; $display("FAIL rstpost_rearm_addr: got %0d want 0", last_wr_addr); end
    tests_run++; if (mem[1][0] !== samp(500, 1)) begin failed++; $display("FAIL rstpost_rearm_data: got %h want %h", mem[1][0], samp(500, 1)); end
  endtask

  initial begin
    rst       = 1'b1;
    cap_start = 1'b0;
    cap_abort = 1'b0;
    trig      = 1'b0;
    post_cnt  = '0;
    din_vld   = 1'b0;
    din       = '0;
    rd_req    = 1'b0;
    rd_addr   = '0;
    rd_bank   = '0;
    test_reset();
    test_capture();
    test_readback();
    test_bad_bank();
    test_wrap();
    test_read_while_busy();
    test_abort();
    test_reset_mid_post();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/capture_mem_ctrl.md
Name: capture_mem_ctrl

Overview:
- Parametrised successor to the fixed 96-bank SRAM wrapper in the pktctrl path.
- Generates capture write addresses for NUM_BANKS parallel SRAM macros as a pre/post-trigger ring buffer.
- Provides a single-bank host readback port with fixed latency.
- Drives active-low CEB/WEB macro pins directly; the macros themselves are instantiated outside this block.

Parameters:
- NUM_BANKS, 96, number of SRAM macros (one sample lane each).
- DATA_W, 9, bits per lane/macro word.
- ADDR_W, 15, macro address width; ring depth = 2**ADDR_W.
- BSEL_W, 7, readback bank-select width; must satisfy 2**BSEL_W >= NUM_BANKS.

Ports:
- clk  in  1  single clock.
- rst  in  1  synchronous reset, active-high.
- cap_start  in  1  pulse; arm a new capture.
- cap_abort  in  1  pulse; stop capture and return to IDLE.
- trig  in  1  trigger qualifier, sampled only when ARMED with din_vld=1.
- post_cnt  in  ADDR_W  samples to store after the trigger; latched on cap_start.
- din_vld  in  1  sample word valid.
- din  in  NUM_BANKS*DATA_W  lane i is din[DATA_W*i +: DATA_W].
- busy  out  1  high in ARMED or POST.
- done  out  1  high in DONE.
- trig_addr  out  ADDR_W  write address of the trigger sample.
- wrapped  out  1  ring has been overwritten at least once since arm.
- rd_req  in  1  readback request; honoured in DONE or IDLE only.
- rd_addr  in  ADDR_W  readback address.
- rd_bank  in  BSEL_W  bank to read.
- rd_vld  out  1  rd_data valid strobe.
- rd_data  out  DATA_W  readback word.
- mem_ceb  out  NUM_BANKS  macro chip enable, active-low.
- mem_web  out  NUM_BANKS  macro write enable, active-low.
- mem_addr  out  NUM_BANKS*ADDR_W  per-macro address.
- mem_d  out  NUM_BANKS*DATA_W  per-macro write data.
- mem_q  in  NUM_BANKS*DATA_W  per-macro read data; macro read latency is 1 cycle.

Behaviour:
- Reset (sync, rst=1): state=IDLE, wr_ptr=0, post_rem=0, trig_addr=0, wrapped=0, busy=0, done=0, rd_vld=0, rd_data=0, mem_ceb=all 1, mem_web=all 1, mem_addr=0, mem_d=0. Reset mid-capture or mid-read discards all in-flight state; memory contents are undefined.
- All mem_* outputs are registered: one cycle from the qualifying input to the macro pins.
- FSM states: IDLE, ARMED, POST, DONE.
- IDLE --cap_start--> ARMED:
  - wr_ptr=0, wrapped=0, done=0.
  - post_cnt latched into post_rem.
- ARMED, each din_vld=1 cycle:
  - All banks written at wr_ptr (ceb=0, web=0, lane i data to mem_d lane i).
  - wr_ptr increments and wraps 2**ADDR_W-1 -> 0.
  - On wrap, wrapped is set and stays set until the next arm.
- ARMED with din_vld=1 and trig=1:
  - The current sample is written and trig_addr=wr_ptr.
  - If post_rem==0: go to DONE. Otherwise go to POST.
  - trig with din_vld=0 is ignored.
- POST, each din_vld=1 cycle:
  - Write, increment wr_ptr, decrement post_rem.
  - After the write that brings post_rem to 0: go to DONE.
  - Writes continue across wrap without limit; the trigger sample can be overwritten when post_cnt >= depth.
- DONE: no writes; done=1; holds until cap_start (re-arm) or rst.
- cap_abort from ARMED or POST -> IDLE the next cycle. An abort in the same cycle as a din_vld write suppresses that write. trig_addr and wrapped hold their values.
- cap_start while busy is ignored. cap_start and cap_abort together: abort wins.
- Readback:
  - rd_req honoured in IDLE or DONE only; ignored while busy, with no rd_vld.
  - Accepted request: the selected bank only gets ceb=0, web=1, addr=rd_addr. All other banks keep ceb=1.
  - rd_vld/rd_data appear 3 cycles after rd_req: registered pins, macro, then output register.
  - Back-to-back requests give one result per cycle, in order.
  - rd_bank >= NUM_BANKS: no macro enabled; rd_vld still pulses with rd_data=0.
  - rd_data holds its value when rd_vld=0.
- Idle banks: ceb=1, web=1, with addr and d held at their last values.

Optional Feature:
- CAPTURE_MEM_RD_PIPE_EN defined: an extra register on the selected mem_q lane before the output register, for timing across wide NUM_BANKS muxes. Read latency becomes 4 cycles; throughput is unchanged.
- Not defined: read latency is 3 cycles as above.

Test Plan:
- ADDR_W=4, NUM_BANKS=4: rst, then cap_start with post_cnt=3; 5 valid samples, trig on the 6th, 3 more -> trig_addr=5, done=1, wr_ptr=9, wrapped=0; banks 0..3 hold lane data at addresses 0..8.
- Same config, 20 pre-trigger samples then trig with post_cnt=0 -> wrapped=1, trig_addr=4, DONE the cycle after the trigger write; no further writes.
- Abort in POST with post_rem=2 and din_vld=1 in the same cycle -> no write that cycle, IDLE next cycle, busy=0, done=0.
- In DONE, rd_req at rd_bank=2 for addresses 5,6,7 on consecutive cycles -> rd_vld for 3 cycles starting 3 cycles later (4 with CAPTURE_MEM_RD_PIPE_EN), data matches the lane 2 writes; only mem_ceb[2]=0.
- rd_req while ARMED -> no mem_ceb activity for the read, rd_vld stays 0. rd_bank=7 with NUM_BANKS=4 in DONE -> rd_vld=1, rd_data=0.
- Assert rst in POST mid-stream -> next cycle every output equals its reset value; a following cap_start starts from wr_ptr=0.
